motor_ramp_driver: RTL and testbench

// - Per-wheel H-bridge drive stage, directly downstream of the Pathing block. Pathing issues

---
 rtl/motor_ramp_driver_pkg.sv | 40 ++++
 rtl/motor_ramp_driver_if.sv | 17 +
 rtl/motor_ramp_driver_pwm_tick_gen.sv | 33 +++
 rtl/motor_ramp_driver.sv | 185 ++++++++++++++++++
 tb/tb_motor_ramp_driver.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/motor_ramp_driver_pkg.sv
// rover_pkg: types and helpers shared by the motor drive stage and the
// Pathing block. Pathing uses the same direction encoding when it issues
// commands.
//   motor_dir_t  - commanded direction (coast / forward / reverse / brake)
//   drv_state_t  - drive stage FSM states
//   ramp_toward  - one slew-limited duty step toward a target
package rover_pkg;

  typedef enum logic [1:0] {
    COAST = 2'b00,
    FWD   = 2'b01,
    REV   = 2'b10,
    BRAKE = 2'b11
  } motor_dir_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_RAMP_DOWN,
    ST_DEADTIME,
    ST_BRAKE
  } drv_state_t;

  // Moves cur toward tgt by at most step. The arithmetic is done at 9 bits,
  // so the result never overshoots the target and never wraps.
  function automatic logic [7:0] ramp_toward(input logic [7:0] cur,
                                             input logic [7:0] tgt,
                                             input logic [7:0] step);
    logic [8:0] gap;
    logic [8:0] mv;
    logic [8:0] nxt;
    if (tgt >= cur) gap = {1'b0, tgt} - {1'b0, cur};
    else            gap = {1'b0, cur} - {1'b0, tgt};
    mv = (gap < {1'b0, step}) ? gap : {1'b0, step};
    if (tgt >= cur) nxt = {1'b0, cur} + mv;
    else            nxt = {1'b0, cur} - mv;
    return 8'(nxt);
  endfunction

endpackage

// File: rtl/motor_ramp_driver_if.sv
// Command channel from Pathing into a motor_ramp_driver.
//   cmd_valid  - command present (Pathing -> driver)
//   cmd_ready  - driver can accept; transfer when valid && ready at clock edge
//   cmd_dir    - requested direction
//   cmd_duty   - requested duty 0..255; ignored for coast and brake
// master = Pathing side, slave = drive stage side.
interface motor_ramp_driver_if;
  import rover_pkg::*;

  logic       cmd_valid;
  logic       cmd_ready;
  motor_dir_t cmd_dir;
  logic [7:0] cmd_duty;

  modport master (output cmd_valid, output cmd_dir, output cmd_duty, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_dir, input cmd_duty, output cmd_ready);
endinterface

// File: rtl/motor_ramp_driver_pwm_tick_gen.sv
// pwm_tick_gen: PWM timebase for one motor.
//   clock     - system clock
//   reset     - asynchronous, active-low reset
//   pwm_step  - one-clock strobe every PWM_DIV clocks
//   pwm_cnt   - PWM counter, 0..254; advances on each strobe and wraps,
//               so one PWM period is 255 steps
module pwm_tick_gen #(
  parameter int PWM_DIV = 100
) (
  input  logic       clock,
  input  logic       reset,
  output logic       pwm_step,
  output logic [7:0] pwm_cnt
);
  localparam int DIV_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PWM_DIV - 1);

  logic [DIV_W-1:0] div_cnt;

  assign pwm_step = (div_cnt == DIV_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
      pwm_cnt <= '0;
    end else if (pwm_step) begin
      div_cnt <= '0;
      pwm_cnt <= (pwm_cnt == 8'd254) ? 8'd0 : pwm_cnt + 8'd1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/motor_ramp_driver.sv
// motor_ramp_driver: per-wheel H-bridge drive stage. Turns Pathing
// direction/duty commands into bridge pins, with slew-limited duty ramps,
// dead-time before a direction reversal, and an emergency brake.
//   clock, reset   - system clock; asynchronous active-low reset
//   cmd            - command channel (slave side of motor_ramp_driver_if)
//   estop          - level-sensitive emergency brake, overrides everything
//   PWM_Out        - bridge enable PWM
//   F_Out / B_Out  - forward / reverse leg
//   duty_now       - duty currently applied
//   busy           - high while ramping down or waiting out dead-time
module motor_ramp_driver
  import rover_pkg::*;
#(
  parameter int PWM_DIV        = 100,
  parameter int RAMP_TICKS     = 400000,
  parameter int RAMP_STEP      = 16,
  parameter int DEADTIME_TICKS = 1000000
) (
  input  logic                clock,
  input  logic                reset,
  motor_ramp_driver_if.slave  cmd,
  input  logic                estop,
  output logic                PWM_Out,
  output logic                F_Out,
  output logic                B_Out,
  output logic [7:0]          duty_now,
  output logic                busy
);
  localparam int RAMP_W = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;
  localparam int DEAD_W = (DEADTIME_TICKS > 1) ? $clog2(DEADTIME_TICKS) : 1;
  localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_TICKS - 1);
  localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEADTIME_TICKS - 1);
  localparam logic [7:0]        STEP8     = 8'(RAMP_STEP);

  drv_state_t        state_q, state_d;
  motor_dir_t        act_dir_q, act_dir_d;
  motor_dir_t        pend_dir_q, pend_dir_d;
  logic [7:0]        pend_duty_q, pend_duty_d;
  logic [7:0]        target_q, target_d;
  logic [7:0]        duty_q, duty_d;
  logic [RAMP_W-1:0] ramp_cnt_q, ramp_cnt_d;
  logic [DEAD_W-1:0] dead_cnt_q, dead_cnt_d;
  logic              reset_done_q;
  logic              accept;
  logic [7:0]        pwm_cnt;
  logic              pwm_step_unused;

  // The PWM compare runs every clock against pwm_cnt, so the step strobe
  // is not needed at this level.
  pwm_tick_gen #(.PWM_DIV(PWM_DIV)) u_tick (
    .clock    (clock),
    .reset    (reset),
    .pwm_step (pwm_step_unused),
    .pwm_cnt  (pwm_cnt)
  );

  assign duty_now = duty_q;
  assign busy     = (state_q == ST_RAMP_DOWN) || (state_q == ST_DEADTIME);

  // reset_done_q holds cmd_ready low until the first edge after reset release.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      act_dir_q    <= COAST;
      pend_dir_q   <= COAST;
      pend_duty_q  <= '0;
      target_q     <= '0;
      duty_q       <= '0;
      ramp_cnt_q   <= '0;
      dead_cnt_q   <= '0;
      reset_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      act_dir_q    <= act_dir_d;
      pend_dir_q   <= pend_dir_d;
      pend_duty_q  <= pend_duty_d;
      target_q     <= target_d;
      duty_q       <= duty_d;
      ramp_cnt_q   <= ramp_cnt_d;
      dead_cnt_q   <= dead_cnt_d;
      reset_done_q <= 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    act_dir_d     = act_dir_q;
    pend_dir_d    = pend_dir_q;
    pend_duty_d   = pend_duty_q;
    target_d      = target_q;
    duty_d        = duty_q;
    ramp_cnt_d    = ramp_cnt_q;
    dead_cnt_d    = dead_cnt_q;
    F_Out         = 1'b0;
    B_Out         = 1'b0;
    PWM_Out       = 1'b0;
    cmd.cmd_ready = 1'b0;

    if (state_q == ST_IDLE || state_q == ST_RUN || state_q == ST_BRAKE)
      cmd.cmd_ready = reset_done_q && !estop;
    accept = cmd.cmd_valid && cmd.cmd_ready;

    // Duty slews toward target only while a leg is driven.
    if (state_q == ST_RUN || state_q == ST_RAMP_DOWN) begin
      F_Out   = (act_dir_q == FWD);
      B_Out   = (act_dir_q == REV);
      PWM_Out = (pwm_cnt < duty_q);
      if (ramp_cnt_q == RAMP_LAST) begin
        ramp_cnt_d = '0;
        duty_d     = ramp_toward(duty_q, target_q, STEP8);
      end else begin
        ramp_cnt_d = ramp_cnt_q + 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (accept && (cmd.cmd_dir == FWD || cmd.cmd_dir == REV)) begin
          act_dir_d  = cmd.cmd_dir;
          target_d   = cmd.cmd_duty;
          duty_d     = '0;
          ramp_cnt_d = '0;
          state_d    = ST_RUN;
        end
      end
      ST_RUN: begin
        if (accept) begin
          ramp_cnt_d = '0;
          if (cmd.cmd_dir == act_dir_q) begin
            target_d = cmd.cmd_duty;
          end else if (cmd.cmd_dir != BRAKE) begin
            // Coast or reversal: slew to zero first; pend_dir decides what follows.
            pend_dir_d  = cmd.cmd_dir;
            pend_duty_d = cmd.cmd_duty;
            target_d    = '0;
            state_d     = ST_RAMP_DOWN;
          end
        end
      end
      ST_RAMP_DOWN: begin
        // Leave on the same edge that brings the duty to zero.
        if (duty_d == 8'd0) begin
          dead_cnt_d = '0;
          state_d    = (pend_dir_q == COAST) ? ST_IDLE : ST_DEADTIME;
        end
      end
      ST_DEADTIME: begin
        if (dead_cnt_q == DEAD_LAST) begin
          act_dir_d  = pend_dir_q;
          target_d   = pend_duty_q;
          duty_d     = '0;
          ramp_cnt_d = '0;
          state_d    = ST_RUN;
        end else begin
          dead_cnt_d = dead_cnt_q + 1'b1;
        end
      end
      ST_BRAKE: begin
        F_Out   = 1'b1;
        B_Out   = 1'b1;
        PWM_Out = 1'b1;
        if (accept && cmd.cmd_dir == COAST) begin
          state_d = ST_IDLE;
        end else if (accept && (cmd.cmd_dir == FWD || cmd.cmd_dir == REV)) begin
          pend_dir_d  = cmd.cmd_dir;
          pend_duty_d = cmd.cmd_duty;
          dead_cnt_d  = '0;
          state_d     = ST_DEADTIME;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Brake wins over everything: ramp and any pending command are dropped.
    if (estop || (cmd.cmd_valid && cmd.cmd_dir == BRAKE)) begin
      state_d     = ST_BRAKE;
      duty_d      = '0;
      target_d    = '0;
      ramp_cnt_d  = '0;
      dead_cnt_d  = '0;
      pend_dir_d  = COAST;
      pend_duty_d = '0;
    end
  end
endmodule

// File: tb/tb_motor_ramp_driver.sv
// tb_motor_ramp_driver: self-checking bench for motor_ramp_driver with a
// short timebase (PWM_DIV=1, RAMP_TICKS=4, RAMP_STEP=16, DEADTIME_TICKS=10).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_motor_ramp_driver;
  import rover_pkg::*;

  typedef struct {
    string       name;
    logic [12:0] val;   // {F, B, PWM, ready, busy, duty[7:0]}
    logic [12:0] mask;
  } exp_t;

  typedef struct {
    string       name;
    motor_dir_t  dir;
    logic [7:0]  duty;
    bit          estop;
    bit          exp_acc;
    logic [12:0] exp_val;
  } vec_t;

  localparam logic [12:0] M_ALL   = 13'h1FFF;
  localparam logic [12:0] M_NOPWM = 13'h1BFF;

  logic       clock;
  logic       reset;
  logic       estop;
  logic       PWM_Out;
  logic       F_Out;
  logic       B_Out;
  logic [7:0] duty_now;
  logic       busy;

  motor_ramp_driver_if bus ();

  motor_ramp_driver #(
    .PWM_DIV(1), .RAMP_TICKS(4), .RAMP_STEP(16), .DEADTIME_TICKS(10)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .cmd      (bus),
    .estop    (estop),
    .PWM_Out  (PWM_Out),
    .F_Out    (F_Out),
    .B_Out    (B_Out),
    .duty_now (duty_now),
    .busy     (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  exp_t sb_q[$];
  vec_t vecs[7];
  int   checks = 0;
  int   errors = 0;
  bit   acc;

  function automatic logic [12:0] pk(bit f, bit b, bit p, bit r, bit bz, int d);
    return {f, b, p, r, bz, 8'(d)};
  endfunction

  function automatic exp_t mk(string nm, logic [12:0] v, logic [12:0] m);
    exp_t e;
    e.name = nm;
    e.val  = v;
    e.mask = m;
    return e;
  endfunction

  function automatic vec_t mv(string nm, motor_dir_t d, int duty, bit es, bit a, logic [12:0] v);
    vec_t x;
    x.name = nm; x.dir = d; x.duty = 8'(duty); x.estop = es; x.exp_acc = a; x.exp_val = v;
    return x;
  endfunction

  // Drive one command for one clock edge; acc reports whether it was accepted.
  task automatic applyStimulus(input motor_dir_t dir, input int duty, input bit es, output bit a);
    bus.cmd_valid = 1'b1;
    bus.cmd_dir   = dir;
    bus.cmd_duty  = 8'(duty);
    estop         = es;
    #1 a = bus.cmd_ready;
    @(negedge clock);
    bus.cmd_valid = 1'b0;
  endtask

  // Pop the oldest expectation and compare against the current outputs.
  task automatic checkOutput();
    exp_t        e;
    logic [12:0] act;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_empty: got no expectation, required one");
      return;
    end
    e   = sb_q.pop_front();
    act = {F_Out, B_Out, PWM_Out, bus.cmd_ready, busy, duty_now};
    if ((act & e.mask) !== (e.val & e.mask)) begin
      errors++;
      $display("[TB] FAIL %s @%0t: got F=%0b B=%0b PWM=%0b ready=%0b busy=%0b duty=%0d, required F=%0b B=%0b PWM=%0b ready=%0b busy=%0b duty=%0d (mask %h)",
               e.name, $time, act[12], act[11], act[10], act[9], act[8], act[7:0],
               e.val[12], e.val[11], e.val[10], e.val[9], e.val[8], e.val[7:0], e.mask);
    end
  endtask

  task automatic checkAccept(input string nm, input bit got, input bit want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s_accept: got %0b, required %0b", nm, got, want);
    end
  endtask

  task automatic expectNow(input string nm, input logic [12:0] v, input logic [12:0] m);
    sb_q.push_back(mk(nm, v, m));
    checkOutput();
  endtask

  // Predicted ramp in RUN: one duty step of at most 16 every 4 edges after the handshake.
  task automatic predictRamp(input string nm, input int start, input int target, input int n,
                             input bit f, input bit b);
    int d = start;
    for (int k = 0; k <= n; k++) begin
      if (k > 0 && k % 4 == 0) begin
        if (target > d) d = (target - d > 16) ? d + 16 : target;
        else if (target < d) d = (d - target > 16) ? d - 16 : target;
      end
      sb_q.push_back(mk($sformatf("%s_k%0d", nm, k), pk(f, b, 0, 1, 0, d), M_NOPWM));
    end
  endtask

  task automatic drain();
    while (sb_q.size() > 0) begin
      checkOutput();
      @(negedge clock);
    end
  endtask

  task automatic countPwm(input string nm, input int want);
    int hi = 0;
    for (int i = 0; i < 255; i++) begin
      hi += int'(PWM_Out);
      @(negedge clock);
    end
    checks++;
    if (hi != want) begin
      errors++;
      $display("[TB] FAIL %s: got %0d high counts per period, required %0d", nm, hi, want);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation still running, required finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vecs[0] = mv("run_brake",     BRAKE, 0, 0, 1, pk(1, 1, 1, 1, 0, 0));
    vecs[1] = mv("brake_coast",   COAST, 0, 0, 1, pk(0, 0, 0, 1, 0, 0));
    vecs[2] = mv("idle_coast",    COAST, 9, 0, 1, pk(0, 0, 0, 1, 0, 0));
    vecs[3] = mv("idle_brake",    BRAKE, 0, 0, 1, pk(1, 1, 1, 1, 0, 0));
    vecs[4] = mv("brake_brake",   BRAKE, 0, 0, 1, pk(1, 1, 1, 1, 0, 0));
    vecs[5] = mv("estop_cmd",     COAST, 0, 1, 0, pk(1, 1, 1, 0, 0, 0));
    vecs[6] = mv("estop_release", COAST, 0, 0, 1, pk(0, 0, 0, 1, 0, 0));

    reset = 1'b0;
    estop = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_dir   = COAST;
    bus.cmd_duty  = 8'd0;
    repeat (2) @(negedge clock);
    expectNow("reset_state", pk(0, 0, 0, 0, 0, 0), M_ALL);
    reset = 1'b1;
    #1 expectNow("release_no_edge", pk(0, 0, 0, 0, 0, 0), M_ALL);
    @(negedge clock);
    expectNow("idle_after_reset", pk(0, 0, 0, 1, 0, 0), M_ALL);

    // Ramp from idle to 128 forward, then check the PWM duty cycle.
    applyStimulus(FWD, 128, 0, acc);
    checkAccept("fwd128", acc, 1);
    predictRamp("fwd128", 0, 128, 32, 1, 0);
    drain();
    countPwm("pwm128", 128);

    // Reversal: ramp down, dead-time, ramp up in reverse.
    applyStimulus(REV, 64, 0, acc);
    checkAccept("rev64", acc, 1);
    for (int k = 0; k <= 58; k++) begin
      if (k < 32)
        sb_q.push_back(mk($sformatf("rampdown_k%0d", k), pk(1, 0, 0, 0, 1, 128 - 16 * (k / 4)), M_NOPWM));
      else if (k < 42)
        sb_q.push_back(mk($sformatf("deadtime_k%0d", k), pk(0, 0, 0, 0, 1, 0), M_ALL));
      else
        sb_q.push_back(mk($sformatf("revup_k%0d", k), pk(0, 1, 0, 1, 0, (16 * ((k - 42) / 4) > 64) ? 64 : 16 * ((k - 42) / 4)), M_NOPWM));
    end
    drain();

    // Single-edge commands from a table.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].dir, int'(vecs[i].duty), vecs[i].estop, acc);
      checkAccept(vecs[i].name, acc, vecs[i].exp_acc);
      expectNow(vecs[i].name, vecs[i].exp_val, M_ALL);
    end

    // Retarget in the same direction, last step clipped, no dead-time.
    applyStimulus(FWD, 100, 0, acc);
    checkAccept("fwd100", acc, 1);
    predictRamp("fwd100", 0, 100, 28, 1, 0);
    drain();
    applyStimulus(FWD, 40, 0, acc);
    checkAccept("fwd40", acc, 1);
    predictRamp("fwd40", 100, 40, 20, 1, 0);
    drain();

    // Duty extremes in RUN.
    applyStimulus(FWD, 0, 0, acc);
    checkAccept("fwd0", acc, 1);
    predictRamp("fwd0", 40, 0, 16, 1, 0);
    drain();
    countPwm("pwm0", 0);
    applyStimulus(FWD, 255, 0, acc);
    checkAccept("fwd255", acc, 1);
    predictRamp("fwd255", 0, 255, 64, 1, 0);
    drain();
    countPwm("pwm255", 255);

    // Estop during dead-time with a command held valid.
    applyStimulus(BRAKE, 0, 0, acc);
    expectNow("brake_again", pk(1, 1, 1, 1, 0, 0), M_ALL);
    applyStimulus(FWD, 50, 0, acc);
    checkAccept("brake_fwd", acc, 1);
    expectNow("brake_to_dead", pk(0, 0, 0, 0, 1, 0), M_ALL);
    repeat (2) @(negedge clock);
    bus.cmd_valid = 1'b1;
    bus.cmd_dir   = REV;
    bus.cmd_duty  = 8'd80;
    estop         = 1'b1;
    #1 checkAccept("estop_dead", bus.cmd_ready, 0);
    @(negedge clock);
    expectNow("estop_brake", pk(1, 1, 1, 0, 0, 0), M_ALL);
    estop         = 1'b0;
    bus.cmd_valid = 1'b0;
    applyStimulus(COAST, 0, 0, acc);
    checkAccept("estop_coast", acc, 1);
    expectNow("estop_idle", pk(0, 0, 0, 1, 0, 0), M_ALL);

    // Reset asserted mid-ramp.
    applyStimulus(FWD, 200, 0, acc);
    repeat (6) @(negedge clock);
    expectNow("midramp_before", pk(1, 0, 0, 1, 0, 16), M_NOPWM);
    #2 reset = 1'b0;
    #1 expectNow("reset_midramp", pk(0, 0, 0, 0, 0, 0), M_ALL);
    @(negedge clock);
    expectNow("reset_held", pk(0, 0, 0, 0, 0, 0), M_ALL);
    reset = 1'b1;
    @(negedge clock);
    expectNow("ready_after_release", pk(0, 0, 0, 1, 0, 0), M_ALL);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
